// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, PC width,
// redirect counter width and the default reset fetch address.
// Imported by fetch_sequencer and fetch_next_pc.
package fetch_sequencer_pkg;

  localparam int PC_W  = 32;
  localparam int CNT_W = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// fetch_next_pc: combinational next-fetch-address selection.
// Ports: pc (current), advance (sequential step allowed), br/jmp redirect
// requests already gated by the caller, optional trap (FETCH_SEQ_TRAP_EN);
// next_pc is the selected address, redirect flags that a target was chosen.
// Priority: trap, branch, jump, sequential advance, hold.
module fetch_next_pc
  import fetch_sequencer_pkg::*;
#(
  parameter int BUNDLE_BYTES = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            advance,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
`ifdef FETCH_SEQ_TRAP_EN
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_vector,
`endif
  output logic [PC_W-1:0] next_pc,
  output logic            redirect
);

  localparam logic [PC_W-1:0] STEP       = PC_W'(BUNDLE_BYTES);
  // Redirect targets are forced onto a bundle boundary.
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - PC_W'(1));

  always_comb begin
    next_pc  = pc;
    redirect = 1'b0;
`ifdef FETCH_SEQ_TRAP_EN
    if (trap_valid) begin
      next_pc  = trap_vector & ALIGN_MASK;
      redirect = 1'b1;
    end else
`endif
    if (br_valid) begin
      next_pc  = br_target & ALIGN_MASK;
      redirect = 1'b1;
    end else if (jmp_valid) begin
      next_pc  = jmp_target & ALIGN_MASK;
      redirect = 1'b1;
    end else if (advance) begin
      // Wraps modulo 2^32 with no flag.
      next_pc = pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: VLIW fetch-address sequencer (IDLE/FETCH/HOLD/REDIRECT).
// Ports: clk (state updates on falling edge), reset (sync, active-high), start,
// stall, br_valid/br_target, jmp_valid/jmp_target, imem_ready; outputs pc,
// pc_write, fetch_valid, flush, redirect_cnt (saturating).
// Optional macro FETCH_SEQ_TRAP_EN adds trap_valid/trap_vector (top priority).
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int              BUNDLE_BYTES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [PC_W-1:0]  br_target,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             imem_ready,
`ifdef FETCH_SEQ_TRAP_EN
  input  logic             trap_valid,
  input  logic [PC_W-1:0]  trap_vector,
`endif
  output logic [PC_W-1:0]  pc,
  output logic             pc_write,
  output logic             fetch_valid,
  output logic             flush,
  output logic [CNT_W-1:0] redirect_cnt
);

  fetch_state_t    state, state_nxt;
  logic            active;
  logic            advance;
  logic            redirect;
  logic [PC_W-1:0] next_pc;

  // Branch/jump requests are ignored while idle; a trap is not.
  assign active = (state != IDLE);

  fetch_next_pc #(
    .BUNDLE_BYTES (BUNDLE_BYTES)
  ) u_next_pc (
    .pc          (pc),
    .advance     (advance),
    .br_valid    (br_valid & active),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid & active),
    .jmp_target  (jmp_target),
`ifdef FETCH_SEQ_TRAP_EN
    .trap_valid  (trap_valid),
    .trap_vector (trap_vector),
`endif
    .next_pc     (next_pc),
    .redirect    (redirect)
  );

  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        fetch_valid = 1'b1;
        if (imem_ready && !stall) advance = 1'b1;
        else                      state_nxt = HOLD;
      end
      HOLD: begin
        // Re-enter FETCH at the same pc; the held bundle is fetched again.
        if (imem_ready && !stall) state_nxt = FETCH;
      end
      REDIRECT: begin
        flush     = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
    // A redirect overrides stall/imem_ready and (re)enters REDIRECT.
    if (redirect) state_nxt = REDIRECT;
    pc_write = !reset && (redirect || advance);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      redirect_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (pc_write) pc <= next_pc;
      if (redirect && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the fetch address loaded on reset.
REQ-002 Parameter BUNDLE_BYTES, default 8, SHALL be the sequential PC increment per VLIW bundle (power of two, 4..32).
REQ-003 clk  in  1  clock; all state SHALL update on the falling edge, matching the PC register timing.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  leaves IDLE and begins fetching.
REQ-006 stall  in  1  pipeline back-pressure; hold current PC.
REQ-007 br_valid  in  1  / br_target  in  32  taken-branch redirect.
REQ-008 jmp_valid  in  1  / jmp_target  in  32  jump redirect.
REQ-009 imem_ready  in  1  instruction memory accepts the current fetch.
REQ-010 pc  out  32  current fetch address.
REQ-011 pc_write  out  1  write enable driven to the 32-bit PC register.
REQ-012 fetch_valid  out  1  pc is a valid fetch request.
REQ-013 flush  out  1  kill the in-flight bundle in the decode stage.
REQ-014 redirect_cnt  out  16  saturating count of accepted redirects.

Function
REQ-015 States SHALL be IDLE, FETCH, HOLD and REDIRECT, encoded as 2 bits.
REQ-016 IDLE: fetch_valid=0 and pc_write=0; the block SHALL go to FETCH on the first edge with start=1.
REQ-017 FETCH: fetch_valid=1; when imem_ready=1, stall=0 and no redirect is present, pc SHALL advance to pc+BUNDLE_BYTES, modulo 2^32, with pc_write=1.
REQ-018 FETCH to HOLD SHALL occur when stall=1 or imem_ready=0; pc holds and pc_write=0.
REQ-019 HOLD to FETCH SHALL occur on the first edge with stall=0 and imem_ready=1; pc SHALL be unchanged on re-entry, with no skip.
REQ-020 Redirect priority SHALL be br_valid, then jmp_valid, then stall, then sequential advance.
REQ-021 A redirect in FETCH or HOLD SHALL load the target into pc at the same edge and set pc_write=1; it overrides stall and imem_ready.
REQ-022 A redirect SHALL enter REDIRECT for exactly one cycle with flush=1 and fetch_valid=0, then return to FETCH.
REQ-023 A redirect asserted while in REDIRECT SHALL be accepted: pc reloads, and the block stays in REDIRECT one more cycle.
REQ-024 Target low log2(BUNDLE_BYTES) bits SHALL be forced to zero before loading.
REQ-025 Redirect inputs in IDLE SHALL be ignored.
REQ-026 redirect_cnt SHALL increment once per accepted redirect and saturate at 16'hFFFF.
REQ-027 pc 32'hFFFF_FFF8 + 8 SHALL wrap to 32'h0000_0000 with no flag.

Reset
REQ-028 On reset=1 at an edge: state=IDLE, pc=RESET_PC, pc_write=0, fetch_valid=0, flush=0, redirect_cnt=0.
REQ-029 Reset SHALL dominate all inputs, including a redirect at the same edge; in-flight state is discarded mid-operation.

Configuration
REQ-030 With macro FETCH_SEQ_TRAP_EN defined, the block SHALL add ports trap_valid (in, 1) and trap_vector (in, 32); trap SHALL have top priority, act as a redirect including in IDLE, and leave the block in REDIRECT.
REQ-031 Without FETCH_SEQ_TRAP_EN, the ports and logic SHALL be absent and behaviour SHALL be as in REQ-020 to REQ-025.

Structure
REQ-032 A shared package SHALL hold the state enum, the 32-bit PC width constant and the RESET_PC default.
REQ-033 The next-PC selection SHALL be a sub-module fetch_next_pc (combinational priority mux plus adder); the state machine and counter SHALL stay in fetch_sequencer.

Verification
REQ-034 Reset, then start=1, imem_ready=1 for 4 cycles -> pc sequence 0, 8, 16, 24, 32; fetch_valid=1 from the first FETCH cycle.
REQ-035 In FETCH at pc=16, stall=1 for 3 cycles -> pc stays 16, pc_write=0, state HOLD; after release, the next accept gives pc=24.
REQ-036 br_valid=1, br_target=32'h104 and jmp_valid=1 at the same edge -> pc=32'h100, flush=1 for one cycle, redirect_cnt=1.
REQ-037 pc=32'hFFFF_FFF8 with an accept -> pc=0; redirect_cnt preloaded to 16'hFFFF, then a redirect -> stays 16'hFFFF.
REQ-038 Reset asserted during REDIRECT together with br_valid -> pc=RESET_PC, state IDLE, flush=0.
REQ-039 With FETCH_SEQ_TRAP_EN, trap_valid and br_valid in IDLE -> pc=trap_vector, state REDIRECT, then FETCH.
